// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/write-back
// and drives the shared ALU / shared memory datapath selects and strobes.
module multicycle_control #(
  parameter int unsigned ALUOP_W     = 3,
  parameter int unsigned MEM_WAIT_EN = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         OP,
  input  logic               Zero,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               RegWrite,
  output logic               MemtoReg,
  output logic               RegDst,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         PCSource,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic [3:0]         State,
  output logic               IllegalOp
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_R_WB      = 4'd7,
    S_EXEC_I    = 4'd8,
    S_I_WB      = 4'd9,
    S_BRANCH    = 4'd10,
    S_JUMP      = 4'd11
  } state_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_J    = 6'h02;

  localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(3'b100);
  localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(3'b011);
  localparam logic [ALUOP_W-1:0] ALU_OR    = ALUOP_W'(3'b101);
  localparam logic [ALUOP_W-1:0] ALU_AND   = ALUOP_W'(3'b110);
  localparam logic [ALUOP_W-1:0] ALU_FUNCT = ALUOP_W'(3'b111);

  state_t     state_q, state_d;
  logic [5:0] op_q;
  logic       ill_q;
  logic       ill_set;
  logic       done;

  // With waiting disabled every memory access is treated as completing at once.
  assign done      = mem_ready || (MEM_WAIT_EN == 0);
  assign State     = state_q;
  assign IllegalOp = ill_q;

  // State, latched opcode and sticky illegal flag registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) op_q <= OP;
      if (ill_set)             ill_q <= 1'b1;
    end
  end

  // Next-state logic; DECODE dispatches on the live opcode, later states on op_q.
  always_comb begin
    state_d = state_q;
    ill_set = 1'b0;
    case (state_q)
      S_FETCH:     if (done) state_d = S_DECODE;
      S_DECODE: begin
        case (OP)
          OP_R:                     state_d = S_EXEC_R;
          OP_ADDI, OP_ORI, OP_ANDI: state_d = S_EXEC_I;
          OP_LW, OP_SW:             state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE:           state_d = S_BRANCH;
          OP_J:                     state_d = S_JUMP;
          default: begin
            state_d = S_FETCH;
            ill_set = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR:  state_d = (op_q == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  if (done) state_d = S_MEM_WB;
      S_MEM_WB:    state_d = S_FETCH;
      S_MEM_WRITE: if (done) state_d = S_FETCH;
      S_EXEC_R:    state_d = S_R_WB;
      S_R_WB:      state_d = S_FETCH;
      S_EXEC_I:    state_d = S_I_WB;
      S_I_WB:      state_d = S_FETCH;
      S_BRANCH:    state_d = S_FETCH;
      S_JUMP:      state_d = S_FETCH;
      default:     state_d = S_FETCH;
    endcase
  end

  // Datapath controls decoded from state and op_q; strobes are gated off during reset.
  always_comb begin
    PCWrite  = 1'b0;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    RegWrite = 1'b0;
    MemtoReg = 1'b0;
    RegDst   = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    PCSource = 2'b00;
    ALUOp    = '0;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        ALUOp   = ALU_ADD;
        IRWrite = done;
        PCWrite = done;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        ALUOp   = ALU_ADD;
      end
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp   = ALU_ADD;
      end
      S_MEM_READ: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEM_WB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEM_WRITE: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALU_FUNCT;
      end
      S_R_WB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        case (op_q)
          OP_ORI:  ALUOp = ALU_OR;
          OP_ANDI: ALUOp = ALU_AND;
          default: ALUOp = ALU_ADD;
        endcase
      end
      S_I_WB: RegWrite = 1'b1;
      S_BRANCH: begin
        ALUSrcA  = 1'b1;
        ALUOp    = ALU_SUB;
        PCSource = 2'b01;
        PCWrite  = ((op_q == OP_BEQ) && Zero) || ((op_q == OP_BNE) && !Zero);
      end
      S_JUMP: begin
        PCSource = 2'b10;
        PCWrite  = 1'b1;
      end
      default: ;
    endcase
    if (!reset) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
      MemRead  = 1'b0;
    end
  end

endmodule
